// File: rtl/pwm_pkg.sv
// Shared constants for the sine PWM generator: Q1.15 sine table and the
// scaling helper used to elaborate each channel's duty LUT.
package pwm_pkg;

  localparam int SIN_LEN = 36;

  localparam logic signed [15:0] SIN_Q15 [0:SIN_LEN-1] = '{
    16'sd0,      16'sd5690,   16'sd11207,  16'sd16384,  16'sd21063,  16'sd25102,
    16'sd28378,  16'sd30792,  16'sd32270,  16'sd32767,  16'sd32270,  16'sd30792,
    16'sd28378,  16'sd25102,  16'sd21063,  16'sd16384,  16'sd11207,  16'sd5690,
    16'sd0,     -16'sd5690,  -16'sd11207, -16'sd16384, -16'sd21063, -16'sd25102,
   -16'sd28378, -16'sd30792, -16'sd32270, -16'sd32767, -16'sd32270, -16'sd30792,
   -16'sd28378, -16'sd25102, -16'sd21063, -16'sd16384, -16'sd11207, -16'sd5690
  };

  // Rescale Q1.15 to +/-(2**(r-1)-1), rounding halves away from zero.
  function automatic int sin_lut(input int i, input int r);
    int v;
    int m;
    int p;
    v = int'(SIN_Q15[i % SIN_LEN]);
    m = (1 << (r - 1)) - 1;
    p = v * m;
    if (p >= 0) return (p + 16384) >>> 15;
    return -((-p + 16384) >>> 15);
  endfunction

endpackage

// File: rtl/pwm_canal.sv
// One PWM channel: phase-offset sine lookup, amplitude scaling with
// saturation, carrier-synchronous duty update and output comparator.
module pwm_canal
  import pwm_pkg::*;
#(
  parameter int R     = 6,
  parameter int AW    = 8,
  parameter int STEPS = 36,
  parameter int SW    = 6,
  parameter int OFFS  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          pend_i,
  input  logic [R-1:0]  q_i,
  input  logic [SW-1:0] step_i,
  input  logic [AW-1:0] amp_i,
  output logic          pwm_o
);

  localparam int PW = R + AW + 1;

  logic signed [R-1:0]  lut [STEPS];
  logic        [SW:0]   idx_sum;
  logic        [SW-1:0] idx;
  logic signed [R-1:0]  s_val;
  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] d_wide;
  logic        [R-1:0]  duty_shd;
  logic        [R-1:0]  duty_act_q;
  logic                 pwm_q;
  logic                 pwm_d;

  function automatic logic [R-1:0] sat_duty(input logic signed [PW-1:0] v);
    if (v < 0) return '0;
    if (v > PW'((2 ** R) - 1)) return '1;
    return v[R-1:0];
  endfunction

  for (genvar i = 0; i < STEPS; i++) begin : g_lut
    assign lut[i] = R'(sin_lut(i * SIN_LEN / STEPS, R));
  end

  // Shadow duty follows the step that will be active after the next pend.
  always_comb begin
    idx_sum = {1'b0, step_i} + (SW+1)'(OFFS);
    if (idx_sum >= (SW+1)'(STEPS)) idx = SW'(idx_sum - (SW+1)'(STEPS));
    else                           idx = idx_sum[SW-1:0];
    s_val    = lut[idx];
    s_ext    = PW'(s_val);
    a_ext    = $signed({{(R+1){1'b0}}, amp_i});
    prod     = s_ext * a_ext;
    d_wide   = PW'(2 ** (R - 1)) + (prod >>> AW);
    duty_shd = sat_duty(d_wide);
    pwm_d    = en_i & (q_i < duty_act_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act_q <= R'(2 ** (R - 1));
      pwm_q      <= 1'b0;
    end else begin
      if (pend_i) duty_act_q <= duty_shd;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_seno_multicanal.sv
// Multi-channel sine PWM: shared carrier counter and step sequencer feeding
// CH phase-shifted channels.
module pwm_seno_multicanal
  import pwm_pkg::*;
#(
  parameter int R     = 6,
  parameter int STEPS = 36,
  parameter int CH    = 3,
  parameter int NW    = 12,
  parameter int AW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [NW-1:0]            n_div,
  input  logic [AW-1:0]            amp,
  output logic [CH-1:0]            pwm_out,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_tick
);

  localparam int SW = $clog2(STEPS);

  logic [R-1:0]  q_q, q_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] n_lim;
  logic [SW-1:0] step_q, step_d;
  logic          tick_q, tick_d;
  logic          pend;
  logic          adv;

  // n_div of zero behaves as one; compared live so a lowered divider acts at once.
  always_comb begin
    n_lim  = (n_div == '0) ? '0 : n_div - NW'(1);
    pend   = en & (q_q == '1);
    adv    = (n_q >= n_lim);
    q_d    = en ? q_q + R'(1) : q_q;
    n_d    = n_q;
    step_d = step_q;
    tick_d = 1'b0;
    if (pend) begin
      if (adv) begin
        n_d    = '0;
        step_d = (step_q == SW'(STEPS - 1)) ? '0 : step_q + SW'(1);
        tick_d = 1'b1;
      end else begin
        n_d = n_q + NW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= '0;
      n_q    <= '0;
      step_q <= '0;
      tick_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      n_q    <= n_d;
      step_q <= step_d;
      tick_q <= tick_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_canal
    pwm_canal #(
      .R     (R),
      .AW    (AW),
      .STEPS (STEPS),
      .SW    (SW),
      .OFFS  (k * STEPS / CH)
    ) u_canal (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .pend_i (pend),
      .q_i    (q_q),
      .step_i (step_d),
      .amp_i  (amp),
      .pwm_o  (pwm_out[k])
    );
  end

  assign step_idx  = step_q;
  assign step_tick = tick_q;

endmodule
